imm_extend_pipe: RTL

- Registered, handshaked successor of the CPU's combinational immediate extender.
- Sits between decode and the scalar/vector execute operand muxes.
- Takes a 24-bit instruction immediate field and a mode, then produces:
  - a DATA_W-wide extended immediate;
  - a lane-replicated vector immediate;
  - an illegal-mode flag.
- A 2-entry skid buffer decouples decode from execute stalls; flush supports branch redirect.

---
 rtl/imm_pkg.sv | 20 ++
 rtl/imm_extend_pipe_if.sv | 33 +++
 rtl/imm_extend_core.sv | 39 +++
 rtl/imm_extend_pipe.sv | 85 ++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types for the immediate extender: mode encoding, field width, buffered entry.
// Entries carry a 64-bit extension so every legal DATA_W is a simple truncation.
package imm_pkg;

    localparam int IMM_FIELD_W = 24;
    localparam int IMM_EXT_W   = 64;

    typedef enum logic [1:0] {
        IMM_U8  = 2'b00,
        IMM_U12 = 2'b01,
        IMM_BR  = 2'b10,
        IMM_ROT = 2'b11
    } imm_src_t;

    typedef struct packed {
        logic [IMM_EXT_W-1:0] ext;
        logic                 err;
    } imm_entry_t;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-to-execute immediate handshake bundle.
// master drives the immediate field and consumer ready; slave is the extender.
interface imm_extend_pipe_if #(
    parameter int DATA_W   = 32,
    parameter int LANES    = 4,
    parameter int LANE_W   = 8,
    parameter int ERRCNT_W = 8
);
    import imm_pkg::*;

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [IMM_FIELD_W-1:0]  instr;
    logic [1:0]              imm_src;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       ext_imm;
    logic [LANES*LANE_W-1:0] vec_imm;
    logic                    imm_err;
    logic [ERRCNT_W-1:0]     err_count;

    modport master (
        output flush, in_valid, instr, imm_src, out_ready,
        input  in_ready, out_valid, ext_imm, vec_imm, imm_err, err_count
    );

    modport slave (
        input  flush, in_valid, instr, imm_src, out_ready,
        output in_ready, out_valid, ext_imm, vec_imm, imm_err, err_count
    );

endinterface

// File: rtl/imm_extend_core.sv
// Immediate mode decode/extension; mode 11 rotates only with IMMEXT_ROTATE_EN defined.
// Latency: combinational.
// Backpressure: none, stateless.
module imm_extend_core
    import imm_pkg::*;
(
    input  logic [IMM_FIELD_W-1:0] instr,
    input  imm_src_t               imm_src,
    output imm_entry_t             entry
);

`ifdef IMMEXT_ROTATE_EN
    logic [31:0] rot_src;
    logic [5:0]  rot_amt;
    logic [31:0] rot_val;

    // Shifting a 32-bit value by 32 yields zero, so a zero rotate needs no special case.
    assign rot_src = {24'b0, instr[7:0]};
    assign rot_amt = {1'b0, instr[11:8], 1'b0};
    assign rot_val = (rot_src >> rot_amt) | (rot_src << (6'd32 - rot_amt));
`endif

    always_comb begin
        entry = '0;
        case (imm_src)
            IMM_U8:  entry.ext = IMM_EXT_W'(instr[7:0]);
            IMM_U12: entry.ext = IMM_EXT_W'(instr[11:0]);
            IMM_BR:  entry.ext = IMM_EXT_W'($signed({instr, 2'b00}));
            IMM_ROT: begin
`ifdef IMMEXT_ROTATE_EN
                entry.ext = IMM_EXT_W'(rot_val);
`else
                entry.err = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with 2-entry skid buffer and saturating illegal-mode counter (IMMEXT_ROTATE_EN enables mode 11).
// Latency: 1 cycle from input transfer to output when the buffer is empty.
// Backpressure: registered in_ready drops while 2 entries are held; head holds stable while out_ready=0.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LANES    = 4,
    parameter int LANE_W   = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    imm_extend_pipe_if.slave bus
);

    imm_entry_t          new_entry;
    imm_entry_t          hd;
    imm_entry_t          sk;
    logic [1:0]          cnt;
    logic [1:0]          cnt_nx;
    logic                in_ready_q;
    logic [ERRCNT_W-1:0] err_cnt_q;
    logic                in_xfer;
    logic                out_xfer;
    logic                unused_ext;

    imm_extend_core u_core (
        .instr   (bus.instr),
        .imm_src (imm_src_t'(bus.imm_src)),
        .entry   (new_entry)
    );

    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = (cnt != 2'd0) && bus.out_ready;

    always_comb begin
        cnt_nx = cnt;
        case (cnt)
            2'd0: if (in_xfer) cnt_nx = 2'd1;
            2'd1: begin
                if (in_xfer && !out_xfer)      cnt_nx = 2'd2;
                else if (out_xfer && !in_xfer) cnt_nx = 2'd0;
            end
            2'd2: if (out_xfer) cnt_nx = 2'd1;
            default: cnt_nx = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 2'd0;
            in_ready_q <= 1'b1;
            hd         <= '0;
            sk         <= '0;
            err_cnt_q  <= '0;
        end else if (bus.flush) begin
            // Output registers keep their last value; only occupancy is dropped.
            cnt        <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            cnt        <= cnt_nx;
            in_ready_q <= (cnt_nx != 2'd2);
            if (in_xfer && (cnt == 2'd0 || (cnt == 2'd1 && out_xfer)))
                hd <= new_entry;
            if (in_xfer && cnt == 2'd1 && !out_xfer)
                sk <= new_entry;
            if (out_xfer && cnt == 2'd2)
                hd <= sk;
            if (in_xfer && new_entry.err && err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
        end
    end

    // Entries are carried at full package width; bits above DATA_W are dropped here.
    assign unused_ext    = ^hd.ext;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (cnt != 2'd0);
    assign bus.ext_imm   = hd.ext[DATA_W-1:0];
    assign bus.vec_imm   = {LANES{hd.ext[LANE_W-1:0]}};
    assign bus.imm_err   = hd.err;
    assign bus.err_count = err_cnt_q;

endmodule
